// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage : MEM pipeline stage.
//
// Accepts the EX result bundle into a pipe register, issues data-memory
// requests over a req/ack handshake, steers byte/half/word lanes, extends
// sub-word load data, implements LL/SC through a link register and presents
// registered results to WB.
//
// Ports
//   clk, rst            clock (rising edge) / asynchronous active-high reset
//   valid_in .. jal_in  EX bundle (PC, ALU result, store data, dest reg, controls)
//   stall_out           upstream hold; the EX bundle is not accepted this cycle
//   dmem_req/we/addr/wdata/be   data-memory request, stable until dmem_ack
//   dmem_ack, dmem_rdata        memory completion and read data
//   valid_out .. addrErr_out    registered WB bundle (valid_out pulses once)
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] aluRes_in,
    input  logic [DATA_W-1:0] rtData_in,
    input  logic [REG_AW-1:0] wrReg_in,
    input  logic              regWrite_in,
    input  logic              memRead_in,
    input  logic              memWrite_in,
    input  logic              atomic_in,
    input  logic [1:0]        mMask_in,
    input  logic              signExt_in,
    input  logic              jal_in,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              valid_out,
    output logic [REG_AW-1:0] wrReg_out,
    output logic              regWrite_out,
    output logic [DATA_W-1:0] wbData_out,
    output logic [DATA_W-1:0] pc_out,
    output logic              addrErr_out
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Access-size alignment: byte always legal, half needs even, word needs /4.
    function automatic logic is_aligned(input logic [1:0] mask, input logic [1:0] off);
        logic ok;
        case (mask)
            2'b10:   ok = 1'b1;
            2'b01:   ok = ~off[0];
            default: ok = (off == 2'b00);
        endcase
        return ok;
    endfunction

    // Byte enables for the access size and byte offset (little-endian lanes).
    function automatic logic [3:0] lane_be(input logic [1:0] mask, input logic [1:0] off);
        logic [3:0] be;
        case (mask)
            2'b10:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes so any enabled lane carries it.
    function automatic logic [31:0] lane_wdata(input logic [1:0] mask, input logic [31:0] rt);
        logic [31:0] wd;
        case (mask)
            2'b10:   wd = {4{rt[7:0]}};
            2'b01:   wd = {2{rt[15:0]}};
            default: wd = rt;
        endcase
        return wd;
    endfunction

    // Pick the addressed lane out of the read word and sign/zero-extend it.
    function automatic logic [31:0] load_extend(input logic [1:0] mask, input logic [1:0] off,
                                                input logic sext, input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] res;
        shifted = rdata >> {off, 3'b000};
        half    = off[1] ? rdata[31:16] : rdata[15:0];
        case (mask)
            2'b10:   res = {{24{sext & shifted[7]}}, shifted[7:0]};
            2'b01:   res = {{16{sext & half[15]}}, half};
            default: res = rdata;
        endcase
        return res;
    endfunction

    logic [0:0]        state_r;
    logic              p_valid_r;
    logic [DATA_W-1:0] p_pc_r;
    logic [DATA_W-1:0] p_alu_r;
    logic [REG_AW-1:0] p_wr_reg_r;
    logic              p_reg_write_r;
    logic              p_load_r;
    logic              p_store_r;
    logic              p_atomic_r;
    logic [1:0]        p_mask_r;
    logic              p_sext_r;
    logic              p_jal_r;
    logic              p_err_r;
    logic              p_sc_ok_r;
    logic              link_valid_r;
    logic [DATA_W-3:0] link_addr_r;

    logic              capture_s;
    logic              in_load_s;
    logic              in_store_s;
    logic              in_sc_s;
    logic              in_err_s;
    logic              in_sc_ok_s;
    logic              in_go_wait_s;
    logic              link_fwd_valid_s;
    logic [DATA_W-3:0] link_fwd_addr_s;
    logic              link_next_valid_s;
    logic              complete_s;
    logic [DATA_W-1:0] wb_data_s;

    // Upstream hold while an access is outstanding and not completing.
    assign stall_out = (state_r == ST_WAIT) & ~dmem_ack;
    assign capture_s = ~stall_out;

    // Decode of the incoming bundle; a store flag wins if both read and write are set.
    always_comb begin
        in_store_s = memWrite_in;
        in_load_s  = memRead_in & ~memWrite_in;
        in_sc_s    = valid_in & memWrite_in & atomic_in;
        in_err_s   = valid_in & (in_load_s | in_store_s) & ~is_aligned(mMask_in, aluRes_in[1:0]);
    end

    // Link state as it will be after this edge's completion, so an SC captured
    // on the same edge an LL/SW acks sees the effect of that older access.
    always_comb begin
        link_fwd_valid_s = link_valid_r;
        link_fwd_addr_s  = link_addr_r;
        if ((state_r == ST_WAIT) && dmem_ack) begin
            if (p_load_r && p_atomic_r) begin
                link_fwd_valid_s = 1'b1;
                link_fwd_addr_s  = p_alu_r[DATA_W-1:2];
            end else if (p_store_r && !p_atomic_r && (p_alu_r[DATA_W-1:2] == link_addr_r)) begin
                link_fwd_valid_s = 1'b0;
            end else begin
                link_fwd_valid_s = link_valid_r;
            end
        end else begin
            link_fwd_valid_s = link_valid_r;
        end
    end

    // SC outcome and the decision to start a memory access for the incoming op.
    always_comb begin
        in_sc_ok_s   = link_fwd_valid_s & (link_fwd_addr_s == aluRes_in[DATA_W-1:2]);
        in_go_wait_s = valid_in & (in_load_s | in_store_s) & ~in_err_s & ~(in_sc_s & ~in_sc_ok_s);
        if (capture_s && in_sc_s) begin
            link_next_valid_s = 1'b0;
        end else begin
            link_next_valid_s = link_fwd_valid_s;
        end
    end

    // An op completes when it sits in the pipe with nothing to wait for, or on its ack.
    always_comb begin
        complete_s = ((state_r == ST_IDLE) & p_valid_r) | ((state_r == ST_WAIT) & dmem_ack);
        if (p_jal_r) begin
            wb_data_s = p_pc_r + 32'd8;
        end else if (p_load_r && !p_err_r) begin
            wb_data_s = load_extend(p_mask_r, p_alu_r[1:0], p_sext_r, dmem_rdata);
        end else if (p_store_r && p_atomic_r) begin
            wb_data_s = {31'd0, p_sc_ok_r & ~p_err_r};
        end else begin
            wb_data_s = p_alu_r;
        end
    end

    // Pipe register and FSM: both advance together whenever the stage accepts a bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            p_valid_r     <= 1'b0;
            p_pc_r        <= 32'd0;
            p_alu_r       <= 32'd0;
            p_wr_reg_r    <= '0;
            p_reg_write_r <= 1'b0;
            p_load_r      <= 1'b0;
            p_store_r     <= 1'b0;
            p_atomic_r    <= 1'b0;
            p_mask_r      <= 2'b00;
            p_sext_r      <= 1'b0;
            p_jal_r       <= 1'b0;
            p_err_r       <= 1'b0;
            p_sc_ok_r     <= 1'b0;
        end else if (capture_s) begin
            state_r       <= in_go_wait_s ? ST_WAIT : ST_IDLE;
            p_valid_r     <= valid_in;
            p_pc_r        <= pc_in;
            p_alu_r       <= aluRes_in;
            p_wr_reg_r    <= wrReg_in;
            p_reg_write_r <= regWrite_in;
            p_load_r      <= valid_in & in_load_s;
            p_store_r     <= valid_in & in_store_s;
            p_atomic_r    <= atomic_in;
            p_mask_r      <= mMask_in;
            p_sext_r      <= signExt_in;
            p_jal_r       <= jal_in;
            p_err_r       <= in_err_s;
            p_sc_ok_r     <= in_sc_ok_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Memory request registers: loaded when an access starts, cleared otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'b0000;
        end else if (capture_s) begin
            dmem_req   <= in_go_wait_s;
            dmem_we    <= in_go_wait_s & in_store_s;
            dmem_addr  <= in_go_wait_s ? {aluRes_in[DATA_W-1:2], 2'b00} : 32'd0;
            dmem_wdata <= in_go_wait_s ? lane_wdata(mMask_in, rtData_in) : 32'd0;
            dmem_be    <= in_go_wait_s ? lane_be(mMask_in, aluRes_in[1:0]) : 4'b0000;
        end else begin
            dmem_req <= dmem_req;
        end
    end

    // Link register for LL/SC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_valid_r <= 1'b0;
            link_addr_r  <= '0;
        end else begin
            link_valid_r <= link_next_valid_s;
            link_addr_r  <= link_fwd_addr_s;
        end
    end

    // WB output registers; payload holds between valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out    <= 1'b0;
            wrReg_out    <= '0;
            regWrite_out <= 1'b0;
            wbData_out   <= 32'd0;
            pc_out       <= 32'd0;
            addrErr_out  <= 1'b0;
        end else if (complete_s) begin
            valid_out    <= 1'b1;
            wrReg_out    <= p_wr_reg_r;
            regWrite_out <= p_reg_write_r & ~p_err_r;
            wbData_out   <= wb_data_s;
            pc_out       <= p_pc_r;
            addrErr_out  <= p_err_r;
        end else begin
            valid_out    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] pc_in, aluRes_in, rtData_in;
    logic [4:0]  wrReg_in;
    logic        regWrite_in, memRead_in, memWrite_in, atomic_in, signExt_in, jal_in;
    logic [1:0]  mMask_in;
    logic        stall_out, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        valid_out, regWrite_out, addrErr_out;
    logic [4:0]  wrReg_out;
    logic [31:0] wbData_out, pc_out;

    mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in), .aluRes_in(aluRes_in),
        .rtData_in(rtData_in), .wrReg_in(wrReg_in), .regWrite_in(regWrite_in),
        .memRead_in(memRead_in), .memWrite_in(memWrite_in), .atomic_in(atomic_in),
        .mMask_in(mMask_in), .signExt_in(signExt_in), .jal_in(jal_in), .stall_out(stall_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .valid_out(valid_out),
        .wrReg_out(wrReg_out), .regWrite_out(regWrite_out), .wbData_out(wbData_out),
        .pc_out(pc_out), .addrErr_out(addrErr_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  wr;
        logic        rw;
        logic [31:0] data;
        logic [31:0] pc;
        logic        err;
    } wb_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } rq_t;

    int checks = 0;
    int errors = 0;

    wb_t exp_q[$];
    rq_t req_q[$];
    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    logic        link_v;
    logic [29:0] link_a;

    int          forced_delay = -1;
    int          stall_cnt = 0;
    int          req_count = 0;
    logic [31:0] last_wb_data;
    logic        last_wb_err, last_wb_rw;
    logic [3:0]  last_req_be;
    logic        last_req_we;
    logic [31:0] last_req_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: sequential instruction semantics applied at acceptance.
    task automatic model_step(input logic [31:0] pc, alu, rt, input logic [4:0] wr,
                              input logic rw, mr, mw, at, input logic [1:0] mk,
                              input logic se, jl);
        int sz, off, idx;
        logic [31:0] d;
        bit ok;
        wb_t e;
        rq_t r;
        sz  = (mk == 2'd2) ? 1 : (mk == 2'd1) ? 2 : 4;
        off = int'(alu % 4);
        idx = int'((alu >> 2) % 16);
        e.wr = wr; e.rw = rw; e.pc = pc; e.err = 1'b0;
        e.data = jl ? pc + 32'd8 : alu;
        r.addr = alu - off;
        r.be   = 4'(((1 << sz) - 1) << off);
        if (mr || mw) begin
            if ((alu % sz) != 0) begin
                e.err = 1'b1; e.rw = 1'b0;
                if (mw && at) link_v = 1'b0;
            end else if (mw) begin
                ok = 1'b1;
                if (at) begin
                    ok = link_v && (link_a == 30'(alu >> 2));
                    link_v = 1'b0;
                    e.data = {31'd0, ok};
                end else if (link_v && (link_a == 30'(alu >> 2))) begin
                    link_v = 1'b0;
                end
                if (ok) begin
                    r.we = 1'b1;
                    r.wdata = (sz == 1) ? {24'd0, rt[7:0]} * 32'h0101_0101 :
                              (sz == 2) ? {16'd0, rt[15:0]} * 32'h0001_0001 : rt;
                    req_q.push_back(r);
                    for (int i = 0; i < 4; i++)
                        if (r.be[i]) ref_mem[idx][8*i +: 8] = r.wdata[8*i +: 8];
                end
            end else begin
                r.we = 1'b0; r.wdata = 32'd0;
                req_q.push_back(r);
                d = ref_mem[idx] >> (8 * off);
                if (sz == 1) begin
                    d = d & 32'h0000_00FF;
                    if (se && d[7]) d = d | 32'hFFFF_FF00;
                end else if (sz == 2) begin
                    d = d & 32'h0000_FFFF;
                    if (se && d[15]) d = d | 32'hFFFF_0000;
                end
                e.data = d;
                if (at) begin link_v = 1'b1; link_a = 30'(alu >> 2); end
            end
        end
        exp_q.push_back(e);
    endtask

    // Drive one bundle (called just after a rising edge) and hold it until accepted.
    task automatic issue(input logic [31:0] pc, alu, rt, input logic [4:0] wr,
                         input logic rw, mr, mw, at, input logic [1:0] mk,
                         input logic se, jl);
        bit done;
        done = 1'b0;
        valid_in = 1'b1; pc_in = pc; aluRes_in = alu; rtData_in = rt; wrReg_in = wr;
        regWrite_in = rw; memRead_in = mr; memWrite_in = mw; atomic_in = at;
        mMask_in = mk; signExt_in = se; jal_in = jl;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (!stall_out) begin
                model_step(pc, alu, rt, wr, rw, mr, mw, at, mk, se, jl);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("capture_timeout", 32'd1, 32'd0);
        valid_in = 1'b0;
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 60 && !idle; n++) begin
            @(negedge clk);
            idle = (exp_q.size() == 0) && (req_q.size() == 0) && !dmem_req;
        end
        if (!idle) chk("drain_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    // Memory responder: checks each new request and acks after a chosen delay.
    initial begin
        bit busy;
        int cnt;
        logic [31:0] hold_addr;
        rq_t r;
        busy = 1'b0; cnt = 0; hold_addr = 32'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                busy = 1'b0; dmem_ack = 1'b0;
            end else if (dmem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, 3));
                    hold_addr = dmem_addr;
                    req_count++;
                    last_req_be = dmem_be; last_req_we = dmem_we; last_req_wdata = dmem_wdata;
                    if (req_q.size() == 0) begin
                        chk("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        r = req_q.pop_front();
                        chk("req_addr", dmem_addr, r.addr);
                        chk("req_we", {31'd0, dmem_we}, {31'd0, r.we});
                        chk("req_be", {28'd0, dmem_be}, {28'd0, r.be});
                        if (r.we) chk("req_wdata", dmem_wdata, r.wdata);
                    end
                end else begin
                    chk("req_addr_stable", dmem_addr, hold_addr);
                end
                if (cnt == 0) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = mem[(dmem_addr >> 2) % 16];
                    if (dmem_we)
                        for (int i = 0; i < 4; i++)
                            if (dmem_be[i]) mem[(dmem_addr >> 2) % 16][8*i +: 8] = dmem_wdata[8*i +: 8];
                    busy = 1'b0;
                end else begin
                    dmem_ack = 1'b0;
                    dmem_rdata = $urandom;
                    cnt--;
                end
            end else begin
                dmem_ack = 1'b0;
            end
        end
    end

    // Compare process: every WB pulse is checked against the model's queue.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stall_out) stall_cnt++;
                if (valid_out) begin
                    last_wb_data = wbData_out; last_wb_err = addrErr_out; last_wb_rw = regWrite_out;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_wb", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wb_wrreg", {27'd0, wrReg_out}, {27'd0, e.wr});
                        chk("wb_regwrite", {31'd0, regWrite_out}, {31'd0, e.rw});
                        chk("wb_pc", pc_out, e.pc);
                        chk("wb_addrerr", {31'd0, addrErr_out}, {31'd0, e.err});
                        if (!e.err) chk("wb_data", wbData_out, e.data);
                    end
                end
            end
        end
    end

    initial begin
        int rc, kind;
        logic [31:0] a, pc;
        rst = 1'b1; valid_in = 1'b0; pc_in = 32'd0; aluRes_in = 32'd0; rtData_in = 32'd0;
        wrReg_in = 5'd0; regWrite_in = 1'b0; memRead_in = 1'b0; memWrite_in = 1'b0;
        atomic_in = 1'b0; mMask_in = 2'b00; signExt_in = 1'b0; jal_in = 1'b0;
        link_v = 1'b0; link_a = 30'd0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_wbdata", wbData_out, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ALU op
        rc = req_count;
        issue(32'h40, 32'h0000_1234, 32'd0, 5'd5, 1, 0, 0, 0, 2'b00, 0, 0);
        drain();
        chk("alu_wbdata", last_wb_data, 32'h0000_1234);
        chk("alu_no_req", req_count, rc);

        // LB sign-extended from lane 3, ack after 3 wait cycles
        mem[0] = 32'h80FF_FF7F; ref_mem[0] = 32'h80FF_FF7F;
        forced_delay = 3; stall_cnt = 0;
        issue(32'h44, 32'h0000_0103, 32'd0, 5'd6, 1, 1, 0, 0, 2'b10, 1, 0);
        drain();
        chk("lb_be", {28'd0, last_req_be}, 32'h8);
        chk("lb_stall_cycles", stall_cnt, 32'd3);
        chk("lb_wbdata", last_wb_data, 32'hFFFF_FF80);
        forced_delay = 0;

        // SH lane replication, then misaligned LH
        issue(32'h48, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 0, 0, 1, 0, 2'b01, 0, 0);
        drain();
        chk("sh_be", {28'd0, last_req_be}, 32'hC);
        chk("sh_wdata", last_req_wdata, 32'hABCD_ABCD);
        chk("sh_we", {31'd0, last_req_we}, 32'd1);
        rc = req_count;
        issue(32'h4C, 32'h0000_0201, 32'd0, 5'd7, 1, 1, 0, 0, 2'b01, 0, 0);
        drain();
        chk("lh_addrerr", {31'd0, last_wb_err}, 32'd1);
        chk("lh_regwrite", {31'd0, last_wb_rw}, 32'd0);
        chk("lh_no_req", req_count, rc);

        // LL / SC success, then SC without link
        issue(32'h50, 32'h0000_0400, 32'd0, 5'd8, 1, 1, 0, 1, 2'b00, 0, 0);
        issue(32'h54, 32'h0000_0400, 32'd7, 5'd9, 1, 0, 1, 1, 2'b00, 0, 0);
        drain();
        chk("sc_we", {31'd0, last_req_we}, 32'd1);
        chk("sc_ok_wbdata", last_wb_data, 32'd1);
        rc = req_count;
        issue(32'h58, 32'h0000_0400, 32'd7, 5'd9, 1, 0, 1, 1, 2'b00, 0, 0);
        drain();
        chk("sc2_no_req", req_count, rc);
        chk("sc2_wbdata", last_wb_data, 32'd0);

        // LL, SW to link address, SC fails; then JAL
        issue(32'h5C, 32'h0000_0400, 32'd0, 5'd8, 1, 1, 0, 1, 2'b00, 0, 0);
        issue(32'h60, 32'h0000_0400, 32'h1111_2222, 5'd0, 0, 0, 1, 0, 2'b00, 0, 0);
        issue(32'h64, 32'h0000_0400, 32'd5, 5'd9, 1, 0, 1, 1, 2'b00, 0, 0);
        drain();
        chk("sc_after_sw", last_wb_data, 32'd0);
        issue(32'h100, 32'hDEAD_BEEF, 32'd0, 5'd31, 1, 0, 0, 0, 2'b00, 0, 1);
        drain();
        chk("jal_wbdata", last_wb_data, 32'h0000_0108);

        // Reset while waiting on memory
        forced_delay = 10;
        issue(32'h68, 32'h0000_0404, 32'd0, 5'd9, 1, 1, 0, 0, 2'b00, 0, 0);
        @(negedge clk);
        chk("req_before_rst", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_mid_valid", {31'd0, valid_out}, 32'd0);
        exp_q.delete(); req_q.delete(); link_v = 1'b0; link_a = 30'd0;
        forced_delay = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        issue(32'h6C, 32'h0000_55AA, 32'd0, 5'd3, 1, 0, 0, 0, 2'b00, 0, 0);
        drain();
        chk("post_rst_alu", last_wb_data, 32'h0000_55AA);

        // Randomized stream
        forced_delay = -1;
        pc = 32'h1000;
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 5));
            a = 32'h400 + $urandom_range(0, 63);
            if (($urandom % 4) != 0) a = a & ~32'h3;
            if ($urandom % 4 == 0) begin
                @(posedge clk); #1;
            end
            case (kind)
                0: issue(pc, $urandom, $urandom, 5'($urandom), 1'($urandom), 0, 0, 0, 2'($urandom), 1'($urandom), 0);
                1: issue(pc, $urandom, $urandom, 5'($urandom), 1, 0, 0, 0, 2'b00, 0, 1);
                2: issue(pc, a, $urandom, 5'($urandom), 1, 1, 0, 0, 2'($urandom), 1'($urandom), 0);
                3: issue(pc, a, $urandom, 5'd0, 0, 0, 1, 0, 2'($urandom), 0, 0);
                4: issue(pc, 32'h400 + 4 * $urandom_range(0, 3), 0, 5'($urandom), 1, 1, 0, 1, 2'b00, 0, 0);
                default: issue(pc, 32'h400 + 4 * $urandom_range(0, 3), $urandom, 5'($urandom), 1, 0, 1, 1, 2'b00, 0, 0);
            endcase
            pc = pc + 32'd4;
        end
        drain();
        chk("leftover_exp", exp_q.size(), 32'd0);
        chk("leftover_req", req_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
